// File: rtl/cpu_pkg.sv
// Shared constants and loader state encoding for the 8-bit CPU program-load path.
// The optional checksum stage is enabled with PROG_LOADER_CHECKSUM_EN.
package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LEN   = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_CSUM  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERROR = 3'd5;

endpackage

// File: rtl/prog_loader.sv
// Program loader: streams length/bytes(/checksum) into the 16x8 program store and holds the
// CPU in reset until a complete image is in. Optional checksum via PROG_LOADER_CHECKSUM_EN.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | after reset, waiting for start
// LEN      | expecting the length byte
// DATA     | writing program bytes at addr 0,1,..
// CSUM     | expecting the XOR checksum byte (macro only)
// DONE     | image loaded, CPU released
// ERROR    | bad length or checksum, CPU held in reset
module prog_loader
  import cpu_pkg::*;
#(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int DEPTH  = cpu_pkg::DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              cpu_resetn,
  output logic              busy,
  output logic              done,
  output logic              err
);

  logic [2:0]        st;
  logic [ADDR_W:0]   rem;
  logic [ADDR_W-1:0] idx;
  logic [DATA_W-1:0] acc;
  logic              xfer;
  logic              len_ok;
  logic              last_byte;

  assign in_ready  = (st == ST_LEN) || (st == ST_DATA) || (st == ST_CSUM);
  assign busy      = in_ready;
  assign xfer      = in_valid && in_ready;
  assign len_ok    = (in_data != '0) && (in_data <= DATA_W'(DEPTH));
  assign last_byte = (rem == (ADDR_W+1)'(1));

  // DONE is masked while the final write strobe is still out, so the CPU is
  // released only once the last word has been committed to the store.
  assign done       = (st == ST_DONE) && !wr_en;
  assign cpu_resetn = done;
  assign err        = (st == ST_ERROR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st      <= ST_IDLE;
      rem     <= '0;
      idx     <= '0;
      acc     <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= 1'b0;
      case (st)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            st  <= ST_LEN;
            idx <= '0;
            acc <= '0;
          end
        end
        ST_LEN: begin
          if (xfer) begin
            if (len_ok) begin
              rem <= in_data[ADDR_W:0];
              st  <= ST_DATA;
            end else begin
              st  <= ST_ERROR;
            end
          end
        end
        ST_DATA: begin
          if (xfer) begin
            wr_en   <= 1'b1;
            wr_addr <= idx;
            wr_data <= in_data;
            acc     <= acc ^ in_data;
            idx     <= idx + 1'b1;
            rem     <= rem - 1'b1;
            if (last_byte) begin
`ifdef PROG_LOADER_CHECKSUM_EN
              st <= ST_CSUM;
`else
              st <= ST_DONE;
`endif
            end
          end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (xfer) st <= (in_data == acc) ? ST_DONE : ST_ERROR;
        end
`endif
        default: st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; follows PROG_LOADER_CHECKSUM_EN if defined.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_ready, wr_en, cpu_resetn, busy, done, err;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;

  int total = 0;
  int bad = 0;
  int wcount = 0;
  int ovl = 0;
  logic [3:0] wa [0:255];
  logic [7:0] wd [0:255];

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_resetn(cpu_resetn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // write log; also counts strobes that overlap DONE / CPU release
  always @(negedge clk) begin
    if (wr_en) begin
      wa[wcount] = wr_addr;
      wd[wcount] = wr_data;
      wcount = wcount + 1;
      if (done || cpu_resetn) ovl = ovl + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int k;
    logic ok;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    ok = 1'b0;
    k = 0;
    while (!ok && k < 50) begin
      if (in_ready) ok = 1'b1;
      tick();
      k++;
    end
    in_valid = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL send_timeout byte=%h in_ready=%b want=1", b, in_ready);
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    total++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_resetn, busy, done, err} !== 18'h0) begin
      bad++;
      $display("FAIL reset_outputs got=%h want=0",
               {in_ready, wr_en, wr_addr, wr_data, cpu_resetn, busy, done, err});
    end
    rst = 1'b0;
    tick();
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset busy=%b in_ready=%b want=0/0", busy, in_ready);
    end
  endtask

  task automatic test_basic();
    int base;
    logic [7:0] d [0:2];
    d[0] = 8'h1A; d[1] = 8'h2B; d[2] = 8'h3C;
    base = wcount;
    pulse_start();
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b1 || cpu_resetn !== 1'b0) begin
      bad++;
      $display("FAIL basic_len_state busy=%b ready=%b cpurstn=%b want=1/1/0", busy, in_ready, cpu_resetn);
    end
    send(8'h03, 0);
    for (int i = 0; i < 3; i++) send(d[i], 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h0D, 0);
`endif
    tick();
    tick();
    total++;
    if (wcount - base !== 3) begin
      bad++;
      $display("FAIL basic_wcount got=%0d want=3", wcount - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (wa[base+i] !== 4'(i) || wd[base+i] !== d[i]) begin
          bad++;
          $display("FAIL basic_write%0d got=%h/%h want=%h/%h", i, wa[base+i], wd[base+i], 4'(i), d[i]);
        end
      end
    end
    total++;
    if (done !== 1'b1 || cpu_resetn !== 1'b1 || err !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL basic_done done=%b cpurstn=%b err=%b busy=%b want=1/1/0/0", done, cpu_resetn, err, busy);
    end
  endtask

  task automatic test_len_err(input logic [7:0] n);
    int base;
    base = wcount;
    pulse_start();
    send(n, 0);
    tick();
    total++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_resetn !== 1'b0 || in_ready !== 1'b0 || wcount != base) begin
      bad++;
      $display("FAIL len_err_%h err=%b done=%b cpurstn=%b ready=%b writes=%0d want=1/0/0/0/0",
               n, err, done, cpu_resetn, in_ready, wcount - base);
    end
  endtask

  task automatic test_full();
    int base;
    logic [7:0] x;
    logic [7:0] b;
    base = wcount;
    x = 8'h00;
    pulse_start();
    send(8'h10, 1);
    for (int i = 0; i < 16; i++) begin
      b = 8'h40 + 8'(i * 7);
      x = x ^ b;
      send(b, int'($urandom_range(0, 3)));
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send(x, 2);
`endif
    repeat (4) tick();
    total++;
    if (wcount - base !== 16) begin
      bad++;
      $display("FAIL full_wcount got=%0d want=16", wcount - base);
    end else begin
      for (int i = 0; i < 16; i++) begin
        b = 8'h40 + 8'(i * 7);
        total++;
        if (wa[base+i] !== 4'(i) || wd[base+i] !== b) begin
          bad++;
          $display("FAIL full_write%0d got=%h/%h want=%h/%h", i, wa[base+i], wd[base+i], 4'(i), b);
        end
      end
    end
    total++;
    if (done !== 1'b1 || cpu_resetn !== 1'b1 || err !== 1'b0 || wr_addr !== 4'hF) begin
      bad++;
      $display("FAIL full_done done=%b cpurstn=%b err=%b addr=%h want=1/1/0/f", done, cpu_resetn, err, wr_addr);
    end
  endtask

`ifdef PROG_LOADER_CHECKSUM_EN
  task automatic test_csum_bad();
    pulse_start();
    send(8'h02, 0);
    send(8'h55, 0);
    send(8'hAA, 0);
    send(8'h00, 0);
    tick();
    tick();
    total++;
    if (err !== 1'b1 || done !== 1'b0 || cpu_resetn !== 1'b0) begin
      bad++;
      $display("FAIL csum_bad err=%b done=%b cpurstn=%b want=1/0/0", err, done, cpu_resetn);
    end
  endtask
`endif

  task automatic test_mid_reset();
    int base;
    pulse_start();
    send(8'h04, 0);
    send(8'hB0, 0);
    send(8'hB1, 0);
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, wr_en, wr_addr, wr_data, cpu_resetn, busy, done, err} !== 18'h0) begin
      bad++;
      $display("FAIL mid_reset_outputs got=%h want=0",
               {in_ready, wr_en, wr_addr, wr_data, cpu_resetn, busy, done, err});
    end
    tick();
    rst = 1'b0;
    tick();
    base = wcount;
    pulse_start();
    send(8'h02, 0);
    send(8'h77, 0);
    send(8'h88, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'hFF, 0);
`endif
    tick();
    tick();
    total++;
    if (wcount - base !== 2 || wa[base] !== 4'h0 || wd[base] !== 8'h77 ||
        wa[base+1] !== 4'h1 || wd[base+1] !== 8'h88 || done !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_reload writes=%0d a0=%h d0=%h a1=%h d1=%h done=%b want=2/0/77/1/88/1",
               wcount - base, wa[base], wd[base], wa[base+1], wd[base+1], done);
    end
  endtask

  task automatic test_back_to_back();
    int base;
    base = wcount;
    pulse_start();
    send(8'h03, 0);
    send(8'hA1, 0);
    pulse_start();
    total++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      bad++;
      $display("FAIL start_in_data busy=%b err=%b want=1/0", busy, err);
    end
    send(8'hA2, 0);
    send(8'hA3, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'hA1 ^ 8'hA2 ^ 8'hA3, 0);
`endif
    tick();
    tick();
    total++;
    if (wcount - base !== 3 || done !== 1'b1 || wa[base+2] !== 4'h2 || wd[base+2] !== 8'hA3) begin
      bad++;
      $display("FAIL ignored_start_load writes=%0d done=%b a2=%h d2=%h want=3/1/2/a3",
               wcount - base, done, wa[base+2], wd[base+2]);
    end
    pulse_start();
    total++;
    if (cpu_resetn !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL start_in_done cpurstn=%b busy=%b done=%b want=0/1/0", cpu_resetn, busy, done);
    end
    base = wcount;
    send(8'h01, 0);
    send(8'h99, 0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'h99, 0);
`endif
    tick();
    tick();
    total++;
    if (wcount - base !== 1 || wa[base] !== 4'h0 || wd[base] !== 8'h99 || done !== 1'b1 || cpu_resetn !== 1'b1) begin
      bad++;
      $display("FAIL reload_overwrite writes=%0d a=%h d=%h done=%b cpurstn=%b want=1/0/99/1/1",
               wcount - base, wa[base], wd[base], done, cpu_resetn);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_err(8'h00);
    test_len_err(8'h11);
    test_full();
`ifdef PROG_LOADER_CHECKSUM_EN
    test_csum_bad();
`endif
    test_mid_reset();
    test_back_to_back();
    total++;
    if (ovl !== 0) begin
      bad++;
      $display("FAIL release_before_last_write got=%0d want=0", ovl);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
